// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - data-memory bus between the access controller and the memory
interface dmem_access_ctrl_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   modport master (
      output dm_req,
      output dm_we,
      output dm_addr,
      output dm_wdata,
      input  dm_rdata,
      input  dm_ack
   );

   modport slave (
      input  dm_req,
      input  dm_we,
      input  dm_addr,
      input  dm_wdata,
      output dm_rdata,
      output dm_ack
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - EX/MEM data-memory access controller with stall, timeout and misalignment trap
module dmem_access_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_dmen,
   input  logic                       mem_memwr,
   input  logic [31:0]                mem_result,
   input  logic [31:0]                mem_rt,
   input  logic [31:0]                mem_pc_i,
   output logic                       pa_idexmemwr,
   dmem_access_ctrl_if.master         dm,
   output logic [31:0]                mem_rdata,
   output logic                       mem_rdata_valid,
   output logic                       bus_err,
   output logic [1:0]                 err_code,
   output logic [31:0]                err_pc,
   input  logic                       err_clr
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        bus_err_q, bus_err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [31:0] err_pc_q, err_pc_d;
   logic        hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
         bus_err_q  <= 1'b0;
         err_code_q <= 2'b00;
         err_pc_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         bus_err_q  <= bus_err_d;
         err_code_q <= err_code_d;
         err_pc_q   <= err_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      bus_err_d  = bus_err_q;
      err_code_d = err_code_q;
      err_pc_d   = err_pc_q;
      hold       = 1'b0;

      case (state_q)
         S_IDLE: begin
            hold = mem_dmen;
            if (mem_dmen) begin
               if (mem_result[1:0] == 2'b00) begin
                  state_d    = S_REQ;
                  wait_cnt_d = 8'd0;
                  addr_d     = mem_result;
                  wdata_d    = mem_rt;
                  we_d       = mem_memwr;
               end else begin
                  state_d    = S_ERR;
                  bus_err_d  = 1'b1;
                  err_code_d = ERR_MISALIGN;
                  err_pc_d   = mem_pc_i;
               end
            end
         end

         S_REQ: begin
            hold = ~dm.dm_ack;
            // An ack in the cycle the count would expire still completes normally.
            if (dm.dm_ack) begin
               state_d = S_IDLE;
               if (!we_q) begin
                  rdata_d  = dm.dm_rdata;
                  rvalid_d = 1'b1;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) begin
                  state_d    = S_ERR;
                  bus_err_d  = 1'b1;
                  err_code_d = ERR_TIMEOUT;
                  err_pc_d   = mem_pc_i;
               end
            end
         end

         S_ERR: begin
            // Releasing the hold on err_clr lets the faulting instruction retire without a retry.
            hold = ~err_clr;
            if (err_clr) begin
               state_d    = S_IDLE;
               bus_err_d  = 1'b0;
               err_code_d = 2'b00;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dm.dm_req       = (state_q == S_REQ);
   assign dm.dm_we        = we_q;
   assign dm.dm_addr      = addr_q;
   assign dm.dm_wdata     = wdata_q;
   assign pa_idexmemwr    = hold;
   assign mem_rdata       = rdata_q;
   assign mem_rdata_valid = rvalid_q;
   assign bus_err         = bus_err_q;
   assign err_code        = err_code_q;
   assign err_pc          = err_pc_q;

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the REQ-state cycle count without dm_ack at which a timeout error fires; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port mem_dmen  input  1  EX/MEM stage holds a data-memory access.
REQ-005 SHALL have port mem_memwr  input  1  access is a store (1) or a load (0).
REQ-006 SHALL have port mem_result  input  32  access byte address.
REQ-007 SHALL have port mem_rt  input  32  store data.
REQ-008 SHALL have port mem_pc_i  input  32  PC of the EX/MEM instruction.
REQ-009 SHALL have port pa_idexmemwr  output  1  pipeline hold; 1 freezes the EX/MEM and earlier registers.
REQ-010 SHALL have port dm_req  output  1  bus request.
REQ-011 SHALL have port dm_we  output  1  bus write enable.
REQ-012 SHALL have port dm_addr  output  32  bus address.
REQ-013 SHALL have port dm_wdata  output  32  bus write data.
REQ-014 SHALL have port dm_rdata  input  32  bus read data; valid with dm_ack.
REQ-015 SHALL have port dm_ack  input  1  bus completion strobe.
REQ-016 SHALL have port mem_rdata  output  32  registered load data.
REQ-017 SHALL have port mem_rdata_valid  output  1  one-cycle strobe qualifying mem_rdata.
REQ-018 SHALL have port bus_err  output  1  sticky error flag.
REQ-019 SHALL have port err_code  output  2  error cause: 01 = timeout, 10 = misaligned.
REQ-020 SHALL have port err_pc  output  32  PC of the faulting instruction.
REQ-021 SHALL have port err_clr  input  1  error acknowledge.

Function
REQ-022 SHALL implement an FSM with the states IDLE, REQ and ERR.
REQ-023 IDLE with mem_dmen=1 and mem_result[1:0]=00 SHALL register dm_addr<=mem_result, dm_wdata<=mem_rt and dm_we<=mem_memwr, then go to REQ.
REQ-024 IDLE with mem_dmen=1 and mem_result[1:0]!=00 SHALL go to ERR with err_code<=10 and err_pc<=mem_pc_i, issuing no bus request.
REQ-025 dm_req SHALL be 1 only in REQ; dm_addr, dm_wdata and dm_we SHALL be stable throughout REQ.
REQ-026 pa_idexmemwr SHALL be combinational:
- 1 in IDLE when mem_dmen=1.
- 1 in REQ when dm_ack=0.
- 1 in ERR when err_clr=0.
- 0 otherwise.
REQ-027 REQ with dm_ack=1 SHALL go to IDLE; the access then advances at that same edge, and minimum access latency is 2 cycles (issue cycle plus 1 REQ cycle).
REQ-028 On a load acknowledged in REQ, mem_rdata SHALL take dm_rdata at that edge, and mem_rdata_valid SHALL be 1 for exactly the following cycle.
REQ-029 mem_rdata_valid SHALL never assert for stores; mem_rdata SHALL hold its value until the next load completes.
REQ-030 An 8-bit wait counter SHALL:
- clear on entry to REQ;
- increment each REQ cycle with dm_ack=0;
- on reaching TIMEOUT with dm_ack=0, send the FSM to ERR with err_code<=01 and err_pc<=mem_pc_i.
REQ-031 If dm_ack=1 in the same cycle the count reaches TIMEOUT, the ack SHALL win: normal completion, no error.
REQ-032 On entry to ERR, bus_err SHALL be set; bus_err, err_code and err_pc SHALL hold until err_clr.
REQ-033 ERR with err_clr=1 SHALL:
- clear bus_err and err_code to 0;
- return to IDLE;
- drop the faulting instruction (hold released that cycle, so it advances without retry).
REQ-034 dm_ack outside REQ and err_clr outside ERR SHALL be ignored.
REQ-035 Only one bus request SHALL be outstanding at a time, and the same access SHALL never be issued twice.

Reset
REQ-036 reset=0 SHALL immediately, independent of clk, force:
- FSM to IDLE and wait counter to 0;
- dm_req, dm_we, mem_rdata_valid, bus_err to 0;
- dm_addr, dm_wdata, mem_rdata, err_pc to 0;
- err_code to 00.
REQ-037 Reset asserted mid-REQ SHALL drop dm_req in the same cycle; a dm_ack arriving afterwards SHALL be ignored.
REQ-038 While in reset, pa_idexmemwr SHALL follow REQ-026 evaluated for state IDLE.
REQ-039 Reset release SHALL take effect at the first rising clk edge with reset=1.

Verification
REQ-040 Load 0x0000_0100, dm_ack on the 1st REQ cycle, dm_rdata=0xDEADBEEF -> hold for 2 cycles, one dm_req pulse, mem_rdata=0xDEADBEEF with mem_rdata_valid=1 for one cycle.
REQ-041 Store 0x0000_0204, data 0x12345678, ack after 4 REQ cycles -> dm_we=1, address and data stable for all 4 cycles, hold for 5 cycles, no mem_rdata_valid.
REQ-042 Load 0x0000_0102 -> no dm_req, bus_err=1, err_code=10, err_pc=mem_pc_i; hold stays asserted until err_clr, then releases in the err_clr cycle.
REQ-043 TIMEOUT=3, no ack -> ERR after 3 REQ cycles with err_code=01; same setup with ack in cycle 3 -> normal completion, no error.
REQ-044 Back-to-back loads, ack immediate each -> two distinct requests, no duplicate issue, 4 total hold cycles.
REQ-045 reset=0 mid-REQ, then a late dm_ack -> dm_req drops asynchronously, all outputs at reset values, late ack has no effect.
